// File: rtl/microseq_addr_ctrl.sv
// -----------------------------------------------------------------------------
// microseq_addr_ctrl
//
// Microprogram sequencer for the microprogrammed RISC-V control unit. Holds the
// registered micro-PC (upc) and picks the next micro-address every clock from:
// sequential increment, one of NUM_DISP runtime-loadable opcode dispatch tables,
// fetch, absolute jump, conditional branch, call/return through an internal
// LIFO return stack, or hold.
//
// Optional build macro:
//   MSEQ_ILLEGAL_TRAP_EN - a dispatch miss goes to TRAP_ADDR instead of
//                          FETCH_ADDR (disp_miss is set in both builds).
//
// Ports:
//   clk, rst    clock; asynchronous active-high reset
//   stall       1 = hold upc, stack and sticky flags (table writes still occur)
//   op          opcode of the current instruction (dispatch index)
//   ctl         address-control field: SEQ/DISP/FETCH/JUMP/BRANCH/CALL/RET/HOLD
//   disp_sel    dispatch table used when ctl=DISP
//   target      jump/branch/call target
//   cond        branch condition
//   tbl_we      dispatch table write enable
//   tbl_sel     table written
//   tbl_idx     entry written
//   tbl_data    entry value (the write also marks the entry valid)
//   upc         current micro-address (registered)
//   sp          return-stack occupancy
//   stack_ovf   sticky: CALL while stack full
//   stack_unf   sticky: RET while stack empty
//   disp_miss   sticky: DISP hit an invalid entry or a nonexistent table
// -----------------------------------------------------------------------------
module microseq_addr_ctrl #(
   parameter  int ADDR_W      = 6,
   parameter  int OP_W        = 7,
   parameter  int NUM_DISP    = 2,
   parameter  int STACK_DEPTH = 4,
   parameter  int FETCH_ADDR  = 0,
   parameter  int TRAP_ADDR   = 2**ADDR_W - 1,
   localparam int SEL_W       = (NUM_DISP > 1) ? $clog2(NUM_DISP) : 1,
   localparam int SP_W        = $clog2(STACK_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic [OP_W-1:0]   op,
   input  logic [2:0]        ctl,
   input  logic [SEL_W-1:0]  disp_sel,
   input  logic [ADDR_W-1:0] target,
   input  logic              cond,
   input  logic              tbl_we,
   input  logic [SEL_W-1:0]  tbl_sel,
   input  logic [OP_W-1:0]   tbl_idx,
   input  logic [ADDR_W-1:0] tbl_data,
   output logic [ADDR_W-1:0] upc,
   output logic [SP_W-1:0]   sp,
   output logic              stack_ovf,
   output logic              stack_unf,
   output logic              disp_miss
);

   typedef enum logic [2:0] {
      CTL_SEQ    = 3'd0,
      CTL_DISP   = 3'd1,
      CTL_FETCH  = 3'd2,
      CTL_JUMP   = 3'd3,
      CTL_BRANCH = 3'd4,
      CTL_CALL   = 3'd5,
      CTL_RET    = 3'd6,
      CTL_HOLD   = 3'd7
   } ctl_e;

   localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int ENTRIES = 2**OP_W;

   localparam logic [ADDR_W-1:0] FETCH_A = ADDR_W'(FETCH_ADDR);
   localparam logic [SP_W-1:0]   SP_FULL = SP_W'(STACK_DEPTH);
`ifdef MSEQ_ILLEGAL_TRAP_EN
   localparam logic [ADDR_W-1:0] MISS_A  = ADDR_W'(TRAP_ADDR);
`else
   localparam logic [ADDR_W-1:0] MISS_A  = FETCH_A;
`endif

   // Elaboration-time parameter sanity checks.
   if (NUM_DISP < 1)                    begin : g_bad_disp  $error("NUM_DISP must be >= 1");           end
   if (STACK_DEPTH < 1)                 begin : g_bad_depth $error("STACK_DEPTH must be >= 1");        end
   if (TRAP_ADDR >= 2**ADDR_W)          begin : g_bad_trap  $error("TRAP_ADDR exceeds address range"); end

   // Storage
   logic [ADDR_W-1:0]                 tbl_mem [NUM_DISP][ENTRIES];
   logic [ADDR_W-1:0]                 stk_mem [STACK_DEPTH];
   logic [NUM_DISP-1:0][ENTRIES-1:0]  valid_q, valid_d;

   logic [ADDR_W-1:0] upc_q, upc_d;
   logic [SP_W-1:0]   sp_q, sp_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              miss_q, miss_d;

   logic              push_en;
   logic [ADDR_W-1:0] upc_inc;
   logic [IDX_W-1:0]  push_idx, pop_idx;
   logic              disp_sel_ok, tbl_sel_ok, disp_hit;

   assign upc_inc     = upc_q + ADDR_W'(1);
   assign push_idx    = sp_q[IDX_W-1:0];
   assign pop_idx     = IDX_W'(sp_q - SP_W'(1));
   assign disp_sel_ok = int'(disp_sel) < NUM_DISP;
   assign tbl_sel_ok  = int'(tbl_sel) < NUM_DISP;
   assign disp_hit    = disp_sel_ok && valid_q[disp_sel][op];

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      upc_d   = upc_q;
      sp_d    = sp_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      miss_d  = miss_q;
      valid_d = valid_q;
      push_en = 1'b0;

      // Table writes ignore stall; a same-cycle DISP still reads the old valid bit.
      if (tbl_we && tbl_sel_ok) valid_d[tbl_sel][tbl_idx] = 1'b1;

      if (!stall) begin
         // Unlisted or X ctl falls through to default and holds upc.
         case (ctl)
            CTL_SEQ:    upc_d = upc_inc;
            CTL_DISP: begin
               if (disp_hit) begin
                  upc_d = tbl_mem[disp_sel][op];
               end else begin
                  upc_d  = MISS_A;
                  miss_d = 1'b1;
               end
            end
            CTL_FETCH:  upc_d = FETCH_A;
            CTL_JUMP:   upc_d = target;
            CTL_BRANCH: upc_d = cond ? target : upc_inc;
            CTL_CALL: begin
               upc_d = target;
               if (sp_q == SP_FULL) begin
                  ovf_d = 1'b1;
               end else begin
                  push_en = 1'b1;
                  sp_d    = sp_q + SP_W'(1);
               end
            end
            CTL_RET: begin
               if (sp_q == '0) begin
                  upc_d = FETCH_A;
                  unf_d = 1'b1;
               end else begin
                  upc_d = stk_mem[pop_idx];
                  sp_d  = sp_q - SP_W'(1);
               end
            end
            default:    upc_d = upc_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         upc_q   <= FETCH_A;
         sp_q    <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         miss_q  <= 1'b0;
         valid_q <= '0;
      end else begin
         upc_q   <= upc_d;
         sp_q    <= sp_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         miss_q  <= miss_d;
         valid_q <= valid_d;
      end
   end

   // NOTE: table and stack storage are not reset; valid bits and sp guard every read.
   always_ff @(posedge clk) begin
      if (tbl_we && tbl_sel_ok) tbl_mem[tbl_sel][tbl_idx] <= tbl_data;
      if (push_en)              stk_mem[push_idx]         <= upc_inc;
   end

   assign upc       = upc_q;
   assign sp        = sp_q;
   assign stack_ovf = ovf_q;
   assign stack_unf = unf_q;
   assign disp_miss = miss_q;

endmodule

// File: tb/tb_microseq_addr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_microseq_addr_ctrl
//
// Self-checking bench for microseq_addr_ctrl with default parameters. Directed
// scenario tasks check against fixed expected values; a randomized phase checks
// every cycle against a queue/array reference model of the sequencer rules.
// Honours MSEQ_ILLEGAL_TRAP_EN for the expected dispatch-miss address.
// -----------------------------------------------------------------------------
module tb_microseq_addr_ctrl;

   localparam int ADDR_W   = 6;
   localparam int OP_W     = 7;
   localparam int NUM_DISP = 2;
   localparam int DEPTH    = 4;
   localparam int N        = 2**ADDR_W;
`ifdef MSEQ_ILLEGAL_TRAP_EN
   localparam int MISS     = N - 1;
`else
   localparam int MISS     = 0;
`endif

   localparam logic [2:0] SEQ = 3'd0, DISP = 3'd1, FETCH = 3'd2, JUMP = 3'd3,
                          BRANCH = 3'd4, CALL = 3'd5, RET = 3'd6, HOLD = 3'd7;

   logic              clk, rst, stall, cond, tbl_we;
   logic [OP_W-1:0]   op, tbl_idx;
   logic [2:0]        ctl;
   logic              disp_sel, tbl_sel;
   logic [ADDR_W-1:0] target, tbl_data, upc;
   logic [2:0]        sp;
   logic              stack_ovf, stack_unf, disp_miss;

   microseq_addr_ctrl dut (
      .clk(clk), .rst(rst), .stall(stall), .op(op), .ctl(ctl),
      .disp_sel(disp_sel), .target(target), .cond(cond),
      .tbl_we(tbl_we), .tbl_sel(tbl_sel), .tbl_idx(tbl_idx), .tbl_data(tbl_data),
      .upc(upc), .sp(sp), .stack_ovf(stack_ovf), .stack_unf(stack_unf),
      .disp_miss(disp_miss)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   int m_upc;
   int m_stk[$];
   bit m_ovf, m_unf, m_miss;
   int m_tbl [NUM_DISP][2**OP_W];
   bit m_vld [NUM_DISP][2**OP_W];

   int n_vec = 0;
   int n_err = 0;

   task automatic model_reset();
      m_upc = 0;
      m_stk.delete();
      m_ovf = 0; m_unf = 0; m_miss = 0;
      foreach (m_vld[s, i]) m_vld[s][i] = 0;
   endtask

   // Apply current inputs for one clock, advancing the model by the sequencer rules.
   task automatic tick();
      int nxt = m_upc;
      int s   = int'(disp_sel);
      if (!stall) begin
         case (ctl)
            SEQ:    nxt = (m_upc + 1) % N;
            DISP:   if (s < NUM_DISP && m_vld[s][op]) nxt = m_tbl[s][op];
                    else begin nxt = MISS; m_miss = 1; end
            FETCH:  nxt = 0;
            JUMP:   nxt = int'(target);
            BRANCH: nxt = cond ? int'(target) : (m_upc + 1) % N;
            CALL: begin
               if (m_stk.size() == DEPTH) m_ovf = 1;
               else m_stk.push_back((m_upc + 1) % N);
               nxt = int'(target);
            end
            RET: begin
               if (m_stk.size() == 0) begin m_unf = 1; nxt = 0; end
               else nxt = m_stk.pop_back();
            end
            default: nxt = m_upc;
         endcase
      end
      if (tbl_we) begin
         m_tbl[tbl_sel][tbl_idx] = int'(tbl_data);
         m_vld[tbl_sel][tbl_idx] = 1;
      end
      @(posedge clk);
      #1;
      m_upc = nxt;
   endtask

   task automatic go(input logic [2:0] c, input logic [ADDR_W-1:0] t, input logic cnd);
      stall = 0; tbl_we = 0; ctl = c; target = t; cond = cnd;
      tick();
   endtask

   task automatic dsp(input logic [OP_W-1:0] o, input logic s);
      op = o; disp_sel = s;
      go(DISP, '0, 1'b0);
   endtask

   task automatic load(input logic s, input logic [OP_W-1:0] idx, input logic [ADDR_W-1:0] d);
      stall = 0; ctl = HOLD; tbl_we = 1; tbl_sel = s; tbl_idx = idx; tbl_data = d;
      tick();
      tbl_we = 0;
   endtask

   task automatic reset_assert();
      stall = 1; ctl = HOLD; tbl_we = 0;
      rst = 1;
      model_reset();
   endtask

   task automatic reset_release();
      @(negedge clk) rst = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #3;
      n_vec++;
      if ({upc, sp, stack_ovf, stack_unf, disp_miss} !== 12'd0) begin
         n_err++;
         $display("FAIL reset_init: upc=%0d sp=%0d flags=%b%b%b expected all 0",
                  upc, sp, stack_ovf, stack_unf, disp_miss);
      end
      reset_release();
      load(0, 7'h10, 6'd7);
      go(CALL, 6'd5, 0);
      go(CALL, 6'd8, 0);
      go(SEQ, 6'd0, 0);
      n_vec++;
      if ({upc, sp} !== {6'd9, 3'd2}) begin
         n_err++;
         $display("FAIL reset_prerun: upc=%0d sp=%0d expected upc=9 sp=2", upc, sp);
      end
      reset_assert();
      #1;
      n_vec++;
      if ({upc, sp, stack_ovf, stack_unf, disp_miss} !== 12'd0) begin
         n_err++;
         $display("FAIL reset_async: upc=%0d sp=%0d flags=%b%b%b expected all 0",
                  upc, sp, stack_ovf, stack_unf, disp_miss);
      end
      reset_release();
      dsp(7'h10, 0);
      n_vec++;
      if ({upc, disp_miss} !== {6'(MISS), 1'b1}) begin
         n_err++;
         $display("FAIL reset_valid_clear: upc=%0d disp_miss=%b expected upc=%0d disp_miss=1",
                  upc, disp_miss, MISS);
      end
   endtask

   task automatic test_dispatch();
      reset_assert();
      reset_release();
      load(0, 7'h33, 6'd6);
      load(1, 7'h03, 6'd3);
      dsp(7'h33, 0);
      n_vec++;
      if (upc !== 6'd6) begin n_err++; $display("FAIL disp_t0: upc=%0d expected 6", upc); end
      dsp(7'h03, 1);
      n_vec++;
      if (upc !== 6'd3) begin n_err++; $display("FAIL disp_t1: upc=%0d expected 3", upc); end
      // Write and dispatch the same entry in one cycle: old data wins.
      op = 7'h33; disp_sel = 0; ctl = DISP; stall = 0;
      tbl_we = 1; tbl_sel = 0; tbl_idx = 7'h33; tbl_data = 6'd5;
      tick();
      tbl_we = 0;
      n_vec++;
      if (upc !== 6'd6) begin n_err++; $display("FAIL disp_wr_same: upc=%0d expected 6", upc); end
      dsp(7'h33, 0);
      n_vec++;
      if (upc !== 6'd5) begin n_err++; $display("FAIL disp_wr_next: upc=%0d expected 5", upc); end
      n_vec++;
      if (disp_miss !== 1'b0) begin n_err++; $display("FAIL disp_no_miss: disp_miss=%b expected 0", disp_miss); end
   endtask

   task automatic test_seq_branch();
      go(JUMP, 6'd63, 0);
      go(SEQ, 6'd0, 0);
      n_vec++;
      if (upc !== 6'd0) begin n_err++; $display("FAIL seq_wrap: upc=%0d expected 0", upc); end
      go(JUMP, 6'd10, 0);
      go(BRANCH, 6'd20, 0);
      n_vec++;
      if (upc !== 6'd11) begin n_err++; $display("FAIL branch_nt: upc=%0d expected 11", upc); end
      go(BRANCH, 6'd20, 1);
      n_vec++;
      if (upc !== 6'd20) begin n_err++; $display("FAIL branch_t: upc=%0d expected 20", upc); end
      go(HOLD, 6'd33, 1);
      n_vec++;
      if (upc !== 6'd20) begin n_err++; $display("FAIL hold: upc=%0d expected 20", upc); end
      go(FETCH, 6'd33, 1);
      n_vec++;
      if (upc !== 6'd0) begin n_err++; $display("FAIL fetch: upc=%0d expected 0", upc); end
   endtask

   task automatic test_call_ret();
      logic [5:0] exp_ret [4] = '{6'd41, 6'd31, 6'd21, 6'd12};
      reset_assert();
      reset_release();
      go(JUMP, 6'd10, 0);
      go(CALL, 6'd40, 0);
      n_vec++;
      if ({upc, sp} !== {6'd40, 3'd1}) begin
         n_err++; $display("FAIL call: upc=%0d sp=%0d expected 40/1", upc, sp);
      end
      go(RET, 6'd0, 0);
      n_vec++;
      if ({upc, sp} !== {6'd11, 3'd0}) begin
         n_err++; $display("FAIL ret: upc=%0d sp=%0d expected 11/0", upc, sp);
      end
      go(CALL, 6'd20, 0);
      go(CALL, 6'd30, 0);
      go(CALL, 6'd40, 0);
      go(CALL, 6'd50, 0);
      go(CALL, 6'd60, 0);
      n_vec++;
      if ({upc, sp, stack_ovf} !== {6'd60, 3'd4, 1'b1}) begin
         n_err++; $display("FAIL call_ovf: upc=%0d sp=%0d ovf=%b expected 60/4/1", upc, sp, stack_ovf);
      end
      for (int i = 0; i < 4; i++) begin
         go(RET, 6'd0, 0);
         n_vec++;
         if ({upc, sp} !== {exp_ret[i], 3'(3 - i)}) begin
            n_err++;
            $display("FAIL ret_lifo%0d: upc=%0d sp=%0d expected %0d/%0d", i, upc, sp, exp_ret[i], 3 - i);
         end
      end
      go(RET, 6'd0, 0);
      n_vec++;
      if ({upc, sp, stack_unf} !== {6'd0, 3'd0, 1'b1}) begin
         n_err++; $display("FAIL ret_unf: upc=%0d sp=%0d unf=%b expected 0/0/1", upc, sp, stack_unf);
      end
   endtask

   task automatic test_stall();
      reset_assert();
      reset_release();
      go(JUMP, 6'd10, 0);
      stall = 1; ctl = CALL; target = 6'd40; cond = 0;
      tbl_we = 1; tbl_sel = 0; tbl_idx = 7'h44; tbl_data = 6'd33;
      for (int i = 0; i < 3; i++) begin
         tick();
         tbl_we = 0;
         n_vec++;
         if ({upc, sp} !== {6'd10, 3'd0}) begin
            n_err++; $display("FAIL stall%0d: upc=%0d sp=%0d expected 10/0", i, upc, sp);
         end
      end
      stall = 0;
      tick();
      go(HOLD, 6'd0, 0);
      n_vec++;
      if ({upc, sp} !== {6'd40, 3'd1}) begin
         n_err++; $display("FAIL stall_release: upc=%0d sp=%0d expected 40/1", upc, sp);
      end
      dsp(7'h44, 0);
      n_vec++;
      if (upc !== 6'd33) begin n_err++; $display("FAIL stall_tbl_write: upc=%0d expected 33", upc); end
   endtask

   task automatic test_disp_miss();
      reset_assert();
      reset_release();
      go(JUMP, 6'd5, 0);
      dsp(7'h7F, 0);
      n_vec++;
      if ({upc, disp_miss} !== {6'(MISS), 1'b1}) begin
         n_err++;
         $display("FAIL disp_miss: upc=%0d disp_miss=%b expected %0d/1", upc, disp_miss, MISS);
      end
   endtask

   task automatic test_random();
      logic [11:0] exp_v;
      for (int i = 0; i < 600; i++) begin
         if (i % 75 == 0) begin
            reset_assert();
            reset_release();
         end
         stall    = ($urandom_range(0, 7) == 0);
         ctl      = 3'($urandom_range(0, 7));
         op       = 7'($urandom_range(0, 7));
         disp_sel = 1'($urandom_range(0, 1));
         target   = 6'($urandom);
         cond     = 1'($urandom);
         tbl_we   = ($urandom_range(0, 3) == 0);
         tbl_sel  = 1'($urandom_range(0, 1));
         tbl_idx  = 7'($urandom_range(0, 7));
         tbl_data = 6'($urandom);
         tick();
         exp_v = {6'(m_upc), 3'(m_stk.size()), m_ovf, m_unf, m_miss};
         n_vec++;
         if ({upc, sp, stack_ovf, stack_unf, disp_miss} !== exp_v) begin
            n_err++;
            $display("FAIL random%0d: upc=%0d sp=%0d ovf/unf/miss=%b%b%b expected upc=%0d sp=%0d ovf/unf/miss=%b%b%b",
                     i, upc, sp, stack_ovf, stack_unf, disp_miss,
                     exp_v[11:6], exp_v[5:3], exp_v[2], exp_v[1], exp_v[0]);
         end
      end
      tbl_we = 0;
   endtask

   initial begin
      op = '0; ctl = HOLD; disp_sel = 0; target = '0; cond = 0;
      tbl_we = 0; tbl_sel = 0; tbl_idx = '0; tbl_data = '0;
      foreach (m_tbl[s, i]) m_tbl[s][i] = 0;
      reset_assert();
      test_reset();
      test_dispatch();
      test_seq_branch();
      test_call_ret();
      test_stall();
      test_disp_miss();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
